// File: rtl/uart_tx_arbiter.sv
// Purpose: packet-level round-robin mux of NUM_SRC byte streams onto the single UART TX stream, optional source tag byte.
// Latency: one arbitration cycle after IDLE, one tag cycle when INSERT_HDR=1, then zero-latency pass-through of packet bytes.
// Backpressure: m_tready is routed only to the granted source in DATA; all other sources (and every source in IDLE/HDR) see s_tready=0.
module uart_tx_arbiter #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_SRC    = 2,
    parameter bit                    INSERT_HDR = 1'b1,
    parameter logic [DATA_WIDTH-1:0] HDR_BASE   = 8'hA0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          busy,
    output logic [2:0]                    grant_id,
    output logic [15:0]                   pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_last_grant;
    logic [2:0]  r_grant_id;
    logic [15:0] r_pkt_count;

    // Sources are widened to the 8-source maximum so a 3-bit index can never fall off the end.
    logic [7:0]              w_vld8;
    logic [7:0]              w_last8;
    logic [8*DATA_WIDTH-1:0] w_data8;
    logic                    w_sel_vld;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [DATA_WIDTH-1:0]   w_tag;
    logic                    w_any;
    logic                    w_hs;
    logic [3:0]              w_idx;
    logic                    w_found;
    logic [2:0]              w_pick;

    assign w_vld8     = 8'(s_tvalid);
    assign w_last8    = 8'(s_tlast);
    assign w_data8    = (8*DATA_WIDTH)'(s_tdata);
    assign w_sel_vld  = w_vld8[r_grant_id];
    assign w_sel_last = w_last8[r_grant_id];
    assign w_sel_data = w_data8[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_tag      = HDR_BASE | DATA_WIDTH'(r_grant_id);
    assign w_any      = |s_tvalid;
    assign w_hs       = m_tvalid & m_tready;

    // Round-robin pick: first requester after the last grant, wrapping modulo NUM_SRC.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        w_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = {1'b0, r_last_grant} + 4'(k);
            if (w_idx >= 4'(NUM_SRC)) begin
                w_idx = w_idx - 4'(NUM_SRC);
            end
            if (!w_found && w_vld8[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[2:0];
            end
        end
    end

    // Output mux: tag byte in HDR, straight pass-through of the granted source in DATA, quiet in IDLE.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        case (r_state)
            ST_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = w_tag;
            end
            ST_DATA: begin
                m_tvalid = w_sel_vld;
                m_tdata  = w_sel_data;
                m_tlast  = w_sel_last;
            end
            default: begin
            end
        endcase
    end

    // Only the granted source sees downstream ready, and only while its bytes are flowing.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_tready[i] = (r_state == ST_DATA) && m_tready && (r_grant_id == 3'(i));
        end
    end

    // Packet FSM: grant locks on arbitration and is released only by an accepted tlast byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 3'(NUM_SRC - 1);
            r_grant_id   <= 3'd0;
            r_pkt_count  <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id   <= w_pick;
                        r_last_grant <= w_pick;
                        r_state      <= INSERT_HDR ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (w_hs) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs && w_sel_last) begin
                        r_state     <= ST_IDLE;
                        r_pkt_count <= r_pkt_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant_id;
    assign pkt_count = r_pkt_count;

endmodule
